seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Takes a snapshot of all digit codes once per frame and scans them with anode-off guard time.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  input  logic [6:0] d7,
  input  logic [6:0] d8,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Cathode pattern for a 5-bit character code; unlisted codes are blank.
  function automatic logic [6:0] seg_decode(input logic [4:0] ch);
    logic [6:0] s;
    case (ch)
      5'h00:   s = 7'h40;
      5'h01:   s = 7'h79;
      5'h02:   s = 7'h24;
      5'h03:   s = 7'h30;
      5'h04:   s = 7'h19;
      5'h05:   s = 7'h61;
      5'h06:   s = 7'h12;
      5'h07:   s = 7'h06;
      5'h08:   s = 7'h07;
      5'h09:   s = 7'h41;
      5'h0A:   s = 7'h0C;
      5'h0B:   s = 7'h03;
      5'h0C:   s = 7'h46;
      5'h0D:   s = 7'h47;
      5'h0E:   s = 7'h11;
      5'h0F:   s = 7'h42;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  state_e           state_q, state_d;
  logic             started_q, started_d;
  logic [7:0][6:0]  snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;
  logic             load_s;
  logic [7:0][6:0]  digits_s;
  logic [6:0]       cur_s;

  assign digits_s = {d8, d7, d6, d5, d4, d3, d2, d1};
  assign cur_s    = snap_q[idx_q];

  // Slot counter, digit index and snapshot load; the first edge after reset only primes the snapshot.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    started_d = started_q;
    load_s    = 1'b0;
    if (!started_q) begin
      started_d = 1'b1;
      load_s    = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      idx_d  = idx_q + 3'd1;
      load_s = (idx_q == 3'd7);
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    if (load_s) begin
      snap_d = digits_s;
    end else begin
      snap_d = snap_q;
    end
    frame_d = load_s;
  end

  // Blank/drive FSM tracks which side of the guard threshold the counter is on.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_d >= BLANK_LIM) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_d < BLANK_LIM) begin
          state_d = ST_BLANK;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Display outputs selected from the current state and snapshot digit.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    case (state_q)
      ST_DRIVE: begin
        an_d = ~(8'h01 << idx_q);
        if (cur_s[6]) begin
          seg_d = seg_decode(cur_s[5:1]);
          dp_d  = cur_s[0];
        end else begin
          seg_d = 7'h7F;
          dp_d  = 1'b1;
        end
      end
      default: begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end
    endcase
  end

  // State, snapshot and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      state_q   <= ST_BLANK;
      started_q <= 1'b0;
      snap_q    <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      started_q <= started_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: each frame pulse queues the 64-cycle display
// sequence expected from the inputs present at that load edge.
module tb_seg7_scan_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] d1 = 7'h00, d2 = 7'h00, d3 = 7'h00, d4 = 7'h00;
  logic [6:0] d5 = 7'h00, d6 = 7'h00, d7 = 7'h00, d8 = 7'h00;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_frame_cyc = 0;
  bit have_prev = 1'b0;
  logic [15:0] sb[$];
  logic [7:0][6:0] d_edge = '0;

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] ref_seg(input logic [6:0] dig);
    if (!dig[6]) return 7'h7F;
    case (dig[5:1])
      5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;  5'h03: return 7'h30;
      5'h04: return 7'h19;  5'h05: return 7'h61;  5'h06: return 7'h12;  5'h07: return 7'h06;
      5'h08: return 7'h07;  5'h09: return 7'h41;  5'h0A: return 7'h0C;  5'h0B: return 7'h03;
      5'h0C: return 7'h46;  5'h0D: return 7'h47;  5'h0E: return 7'h11;  5'h0F: return 7'h42;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic bit an_legal(input logic [7:0] a);
    return (a == 8'hFF) || ($countones(~a) == 1);
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  always @(posedge clock) d_edge <= {d8, d7, d6, d5, d4, d3, d2, d1};

  task automatic push_frame();
    logic [6:0] dig;
    logic [7:0] a;
    for (int k = 0; k < 8; k++) begin
      dig = d_edge[k];
      a = ~(8'h01 << k);
      for (int c = 0; c < 8; c++) begin
        if (c < 2) sb.push_back({8'hFF, 7'h7F, 1'b1});
        else       sb.push_back({a, ref_seg(dig), dig[6] ? dig[0] : 1'b1});
      end
    end
  endtask

  always @(negedge clock) begin
    logic [15:0] e;
    cyc++;
    check_val("an_legal", {31'd0, an_legal(an)}, 32'd1);
    if (!reset) begin
      sb.delete();
      have_prev = 1'b0;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("scan", {16'd0, an, seg, dp}, {16'd0, e});
      end
      if (frame) begin
        if (have_prev) check_val("frame_period", cyc - last_frame_cyc, 64);
        have_prev = 1'b1;
        last_frame_cyc = cyc;
        push_frame();
      end
    end
  end

  task automatic wait_frames(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < n * 64 + 200) begin
      @(negedge clock);
      budget++;
      if (frame) seen++;
    end
    check_val("wait_frame", seen, n);
  endtask

  task automatic wait_an(input logic [7:0] v);
    int budget = 0;
    @(negedge clock);
    while (an !== v && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    check_val("wait_an", {24'd0, an}, {24'd0, v});
  endtask

  initial begin
    int budget;
    repeat (3) @(negedge clock);
    check_val("rst_an", {24'd0, an}, 32'hFF);
    check_val("rst_seg", {25'd0, seg}, 32'h7F);
    check_val("rst_dp", {31'd0, dp}, 32'd1);
    check_val("rst_frame", {31'd0, frame}, 32'd0);

    d1 = 7'h43;
    reset = 1'b1;
    wait_frames(1);

    {d8, d7, d6, d5, d4, d3, d2, d1} = {7'h57, 7'h53, 7'h5B, 7'h5B, 7'h4D, 7'h4F, 7'h5D, 7'h4F};
    wait_frames(2);

    wait_an(8'hFD);
    d3 = 7'h41;
    wait_frames(2);

    d1 = 7'h12;
    wait_frames(2);
    d1 = 7'h40;
    wait_frames(2);
    d1 = 7'h7F;
    wait_frames(2);

    wait_an(8'hDF);
    #2 reset = 1'b0;
    #1 check_val("async_an", {24'd0, an}, 32'hFF);
    check_val("async_frame", {31'd0, frame}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    budget = 0;
    @(negedge clock);
    while (an === 8'hFF && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    check_val("first_lit", {24'd0, an}, 32'hFE);
    wait_frames(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
